// File: rtl/seven_seg_scan_if.sv
// seven_seg_scan_if: BCD digit bundle in, active-low display drive out
//   master: clock stage / bench side; drives the six BCD digits, observes seg/dp/an
//   slave : seven_seg_scan side; consumes the digits, drives seg/dp/an
interface seven_seg_scan_if;
  logic [3:0] sec_1s;
  logic [3:0] sec_10s;
  logic [3:0] min_1s;
  logic [3:0] min_10s;
  logic [3:0] hr_1s;
  logic [3:0] hr_10s;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  modport master (
    output sec_1s, sec_10s, min_1s, min_10s, hr_1s, hr_10s,
    input  seg, dp, an
  );
  modport slave (
    input  sec_1s, sec_10s, min_1s, min_10s, hr_1s, hr_10s,
    output seg, dp, an
  );
endinterface

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: tear-free 4-digit multiplexed seven-segment driver (HH:MM / MM:SS, blinking colon)
//   clk_100MHz : system clock
//   reset      : asynchronous, active-high
//   tick_1Hz   : 1 Hz square wave, asynchronous; drives the colon
//   view_btn   : raw button, each press toggles the view
//   view_mmss  : 0 = HH:MM, 1 = MM:SS
//   disp       : slave side of seven_seg_scan_if (six BCD digits in, seg/dp/an out, all active-low)
//   Optional build macro SEVSEG_LEADING_ZERO_BLANK_EN darkens a leading hour zero in HH:MM view.
module seven_seg_scan #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             tick_1Hz,
  input  logic             view_btn,
  output logic             view_mmss,
  seven_seg_scan_if.slave  disp
);
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [6:0] SEG_LUT [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F
  };
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          act_q, act_d;
  logic [23:0]   din, s1_q, s2_q, shd_q, shd_d, dsp_q, dsp_d;
  logic          vdsp_q, vdsp_d;
  logic [2:0]    tick_q;
  logic [1:0]    btn_q;
  logic [2:0]    db_q;
  logic          qual, qual_q;
  logic          view_q, view_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;
  logic          wrap, frame, blank;
  logic [2:0]    sel;
  logic [3:0]    dig;
  assign din = {disp.hr_10s, disp.hr_1s, disp.min_10s, disp.min_1s, disp.sec_10s, disp.sec_1s};
  // act_q stays low until the first refresh wrap so the display stays dark for the first slot
  // after reset; that first wrap also counts as a frame boundary so the display register gets a
  // real snapshot before any anode is enabled.
  always_comb begin
    wrap   = cnt_q == CW'(REFRESH_DIV - 1);
    frame  = wrap && (!act_q || idx_q == 2'd3);
    cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    act_d  = act_q | wrap;
    idx_d  = (wrap && act_q) ? idx_q + 2'd1 : idx_q;
    shd_d  = (s1_q == s2_q) ? s2_q : shd_q;
    dsp_d  = frame ? shd_q : dsp_q;
    qual   = &db_q;
    view_d = view_q ^ (qual & ~qual_q);
    vdsp_d = frame ? view_d : vdsp_q;
    sel    = {1'b0, idx_q} + (vdsp_q ? 3'd0 : 3'd2);
    dig    = dsp_q[{sel, 2'b00} +: 4];
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    blank  = !vdsp_q && idx_q == 2'd3 && dsp_q[23:20] == 4'd0;
`else
    blank  = 1'b0;
`endif
    an_d   = (!act_q || blank) ? 4'hF : ~(4'b0001 << idx_q);
    seg_d  = (!act_q || blank) ? 7'h7F : SEG_LUT[dig];
    dp_d   = !(act_q && idx_q == 2'd2 && tick_q[2]);
  end
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      act_q  <= 1'b0;
      s1_q   <= '0;
      s2_q   <= '0;
      shd_q  <= '0;
      dsp_q  <= '0;
      vdsp_q <= 1'b0;
      tick_q <= '0;
      btn_q  <= '0;
      db_q   <= '0;
      qual_q <= 1'b0;
      view_q <= 1'b0;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
      an_q   <= 4'hF;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      act_q  <= act_d;
      s1_q   <= din;
      s2_q   <= s1_q;
      shd_q  <= shd_d;
      dsp_q  <= dsp_d;
      vdsp_q <= vdsp_d;
      tick_q <= {tick_q[1:0], tick_1Hz};
      btn_q  <= {btn_q[0], view_btn};
      db_q   <= {db_q[1:0], btn_q[1]};
      qual_q <= qual;
      view_q <= view_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      an_q   <= an_d;
    end
  end
  assign disp.seg  = seg_q;
  assign disp.dp   = dp_q;
  assign disp.an   = an_q;
  assign view_mmss = view_q;
endmodule
